// File: rtl/vga_axil_pkg.sv
// ============================================================================
// Module  : vga_axil_pkg
// Brief   : Shared types for the AXI-Lite to VGA native port controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_axil_pkg;

    localparam int c_native_addr_w = 10;
    localparam int c_axil_data_w   = 32;

    typedef logic [c_native_addr_w-1:0] native_addr_t;
    typedef logic [c_axil_data_w-1:0]   axil_data_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_EXEC = 3'd1,
        WR_RESP = 3'd2,
        RD_EXEC = 3'd3,
        RD_CAPT = 3'd4,
        RD_RESP = 3'd5
    } ctrl_state_t;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/vga_rr_arb2.sv
// ============================================================================
// Module  : vga_rr_arb2
// Brief   : Two-requester round-robin arbiter (read vs write), one-hot grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_rr_arb2
    import vga_axil_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_read,
    input  logic i_req_write,
    input  logic i_grant_en,
    output logic o_grant_read,
    output logic o_grant_write
);

    grant_t r_last_grant;

    // On contention the requester that did not win last time is served.
    always_comb begin
        o_grant_read  = 1'b0;
        o_grant_write = 1'b0;
        if (i_grant_en) begin
            if (i_req_read && i_req_write) begin
                if (r_last_grant == WRITE) begin
                    o_grant_read = 1'b1;
                end else begin
                    o_grant_write = 1'b1;
                end
            end else begin
                o_grant_read  = i_req_read;
                o_grant_write = i_req_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= WRITE;
        end else if (o_grant_read) begin
            r_last_grant <= READ;
        end else if (o_grant_write) begin
            r_last_grant <= WRITE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/vga_axil_native_ctrl.sv
// ============================================================================
// Module  : vga_axil_native_ctrl
// Brief   : AXI-Lite slave sequencing single-beat accesses onto the VGA
//           native register/memory port, one transaction at a time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_axil_native_ctrl
    import vga_axil_pkg::*;
#(
    parameter int AXIL_ADDR_W   = 32,
    parameter int AXIL_DATA_W   = 32,
    parameter int NATIVE_ADDR_W = 10,
    parameter int NATIVE_DEPTH  = 1024,
    parameter int ADDR_LSB      = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXIL_ADDR_W-1:0]   awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [AXIL_DATA_W-1:0]   wdata,
    input  logic [AXIL_DATA_W/8-1:0] wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [AXIL_ADDR_W-1:0]   araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [AXIL_DATA_W-1:0]   rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [NATIVE_ADDR_W-1:0] addr_write,
    output logic [AXIL_DATA_W-1:0]   data2native,
    output logic                     write_en,
    output logic [NATIVE_ADDR_W-1:0] addr_read,
    output logic                     read_en_sync,
    input  logic [AXIL_DATA_W-1:0]   data2axil
);

    localparam logic [AXIL_ADDR_W-1:0] c_depth = AXIL_ADDR_W'(NATIVE_DEPTH);

    ctrl_state_t r_state;
    ctrl_state_t w_state_nxt;

    logic                     w_idle;
    logic                     w_gnt_rd;
    logic                     w_gnt_wr;
    logic                     w_wr_err;
    logic                     w_rd_err;
    logic [AXIL_ADDR_W-1:0]   w_aw_word;
    logic [AXIL_ADDR_W-1:0]   w_ar_word;

    logic                     r_err;
    logic                     r_write_en;
    logic                     r_read_en;
    logic [NATIVE_ADDR_W-1:0] r_addr_write;
    logic [NATIVE_ADDR_W-1:0] r_addr_read;
    logic [AXIL_DATA_W-1:0]   r_data2native;
    logic                     r_bvalid;
    axil_resp_t               r_bresp;
    logic                     r_rvalid;
    axil_resp_t               r_rresp;
    logic [AXIL_DATA_W-1:0]   r_rdata;

    assign w_idle = (r_state == IDLE) && !rst;

    vga_rr_arb2 u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req_read    (arvalid),
        .i_req_write   (awvalid && wvalid),
        .i_grant_en    (w_idle),
        .o_grant_read  (w_gnt_rd),
        .o_grant_write (w_gnt_wr)
    );

    // The native port has no byte enables, so partial strobes are rejected.
    assign w_aw_word = awaddr >> ADDR_LSB;
    assign w_ar_word = araddr >> ADDR_LSB;
    assign w_wr_err  = (w_aw_word >= c_depth) || (wstrb != '1);
    assign w_rd_err  = (w_ar_word >= c_depth);

    assign awready      = w_gnt_wr;
    assign wready       = w_gnt_wr;
    assign arready      = w_gnt_rd;
    assign bvalid       = r_bvalid;
    assign bresp        = r_bresp;
    assign rvalid       = r_rvalid;
    assign rresp        = r_rresp;
    assign rdata        = r_rdata;
    assign write_en     = r_write_en;
    assign read_en_sync = r_read_en;
    assign addr_write   = r_addr_write;
    assign addr_read    = r_addr_read;
    assign data2native  = r_data2native;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_wr) begin
                    w_state_nxt = WR_EXEC;
                end else if (w_gnt_rd) begin
                    w_state_nxt = RD_EXEC;
                end
            end
            WR_EXEC: w_state_nxt = WR_RESP;
            WR_RESP: if (bready) w_state_nxt = IDLE;
            RD_EXEC: w_state_nxt = RD_CAPT;
            RD_CAPT: w_state_nxt = RD_RESP;
            RD_RESP: if (rready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err         <= 1'b0;
            r_write_en    <= 1'b0;
            r_read_en     <= 1'b0;
            r_addr_write  <= '0;
            r_addr_read   <= '0;
            r_data2native <= '0;
            r_bvalid      <= 1'b0;
            r_bresp       <= OKAY;
            r_rvalid      <= 1'b0;
            r_rresp       <= OKAY;
            r_rdata       <= '0;
        end else begin
            r_write_en <= 1'b0;
            r_read_en  <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Native address/data only move on a real strobe.
                    if (w_gnt_wr) begin
                        r_err <= w_wr_err;
                        if (!w_wr_err) begin
                            r_write_en    <= 1'b1;
                            r_addr_write  <= awaddr[ADDR_LSB +: NATIVE_ADDR_W];
                            r_data2native <= wdata;
                        end
                    end else if (w_gnt_rd) begin
                        r_err <= w_rd_err;
                        if (!w_rd_err) begin
                            r_read_en   <= 1'b1;
                            r_addr_read <= araddr[ADDR_LSB +: NATIVE_ADDR_W];
                        end
                    end
                end
                WR_EXEC: begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= r_err ? SLVERR : OKAY;
                end
                WR_RESP: begin
                    if (bready) r_bvalid <= 1'b0;
                end
                RD_CAPT: begin
                    r_rvalid <= 1'b1;
                    r_rresp  <= r_err ? SLVERR : OKAY;
                    r_rdata  <= r_err ? '0 : data2axil;
                end
                RD_RESP: begin
                    if (rready) r_rvalid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/vga_axil_native_ctrl.md
Name: vga_axil_native_ctrl

Overview:
AXI-Lite slave front end that sequences single-beat AXI-Lite reads and writes onto the VGA native register/memory port. It owns the native strobes: `read_en_sync` (synchronous read, data one cycle later) and `write_en`, each one clock wide. When both a read and a write are pending it arbitrates round-robin. Only one transaction is outstanding at a time. It sits between the AXI-Lite interconnect and the VGA register file / framebuffer native port.

Parameters:
AXIL_ADDR_W, 32, AXI-Lite byte address width
AXIL_DATA_W, 32, AXI-Lite and native data width
NATIVE_ADDR_W, 10, native word address width
NATIVE_DEPTH, 1024, number of valid native words; word addresses >= NATIVE_DEPTH are out of range
ADDR_LSB, 2, byte-to-word shift (log2(AXIL_DATA_W/8))

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
awaddr  in  AXIL_ADDR_W  write address
awvalid  in  1  write address valid
awready  out  1  write address ready
wdata  in  AXIL_DATA_W  write data
wstrb  in  AXIL_DATA_W/8  write byte strobes
wvalid  in  1  write data valid
wready  out  1  write data ready
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  write response ready
araddr  in  AXIL_ADDR_W  read address
arvalid  in  1  read address valid
arready  out  1  read address ready
rdata  out  AXIL_DATA_W  read data
rresp  out  2  read response
rvalid  out  1  read response valid
rready  in  1  read response ready
addr_write  out  NATIVE_ADDR_W  native write word address
data2native  out  AXIL_DATA_W  native write data
write_en  out  1  native write strobe, one clock wide
addr_read  out  NATIVE_ADDR_W  native read word address
read_en_sync  out  1  native read strobe, one clock wide
data2axil  in  AXIL_DATA_W  native read data, valid the cycle after read_en_sync

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous, active-high.
- Reset value of every output is 0: the ready signals, `bvalid`/`rvalid`, `bresp`/`rresp`, `rdata`, native addresses, `data2native` and both strobes.
- Reset mid-transaction: the FSM returns to IDLE and the in-flight response is dropped.
- Round-robin state `last_grant` resets to WRITE, so the first contended grant goes to the read.
- FSM states: IDLE, WR_EXEC, WR_RESP, RD_EXEC, RD_CAPT, RD_RESP.
- Address decode: native word address = addr[ADDR_LSB +: NATIVE_ADDR_W].
  - Range check uses the full awaddr/araddr >> ADDR_LSB compared against NATIVE_DEPTH.
  - Low ADDR_LSB address bits are ignored.
- IDLE, acceptance:
  - A write request means `awvalid && wvalid`; AW alone or W alone is never accepted.
  - A read request means `arvalid`.
  - Single request: grant it. Both requests: grant opposite of `last_grant`.
  - Ready signals are combinational, asserted only in IDLE for the granted channel: `awready` and `wready` together, or `arready`.
  - In the handshake cycle T, register the address, wdata, and an error flag.
  - Update `last_grant`.
- Write path:
  - WR_EXEC (T+1): `write_en` = 1 for exactly one cycle, with `addr_write`/`data2native` valid.
  - WR_RESP (from T+2): `bvalid` = 1, held until `bready`, then return to IDLE.
- Read path:
  - RD_EXEC (T+1): `read_en_sync` = 1 for one cycle with `addr_read` valid.
  - RD_CAPT (T+2): `rdata` <= `data2axil`.
  - RD_RESP (from T+3): `rvalid` = 1; `rdata`/`rresp` stable until `rready`, then return to IDLE.
- Error (SLVERR = 2'b10, OKAY = 2'b00):
  - Triggers: out-of-range address, or `wstrb` not all ones (the native port has no byte enables).
  - On error: the native strobe is suppressed but the state sequence and latency are unchanged.
  - Error reads return `rdata` = 0.
- Native `addr_*`/`data2native` hold their last value outside strobe cycles.
- No new request is accepted while in any non-IDLE state. Back-to-back minimum period is 3 cycles (write) / 4 cycles (read) when bready/rready are held high.

Decomposition:
- `vga_axil_pkg` holds:
  - `native_addr_t` and `axil_data_t`
  - `axil_resp_t` enum (OKAY, SLVERR)
  - the FSM state enum
  - the `grant_t` enum (READ, WRITE)
- One sub-module, `vga_rr_arb2`: 2-requester round-robin arbiter with a registered `last_grant`, a grant-enable input, and combinational one-hot grant output.

Test Plan:
- Single write: awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> `write_en` high only at T+1 with addr_write=4 and data2native=0xDEADBEEF; bvalid at T+2 with bresp=OKAY.
- Single read: araddr=0x20, model returns 0x12345678 the cycle after read_en_sync -> addr_read=8 at T+1; rvalid at T+3 with rdata=0x12345678 and rresp=OKAY.
- Contention: awvalid, wvalid and arvalid all high continuously for 4 transactions -> grant order read, write, read, write; never two strobes in one cycle.
- Errors:
  - araddr=NATIVE_DEPTH*4 -> no read_en_sync; rresp=SLVERR and rdata=0 at T+3.
  - wstrb=4'h3 -> no write_en; bresp=SLVERR at T+2.
- Backpressure and partial request:
  - rready=0 for 5 cycles -> rvalid and rdata stable for 5 cycles and arready stays 0.
  - awvalid without wvalid for 3 cycles -> awready stays 0.
- Reset mid-op: assert rst in WR_RESP with bvalid=1 -> next cycle all outputs 0 and FSM in IDLE; a following read completes normally with read granted first.
